// File: rtl/matmul_result_streamer.sv
// Captures a finished M x N result matrix on the core's done pulse and streams it
// row-major over an AXI4-Stream master port, flagging done pulses that arrive mid-stream.
module matmul_result_streamer #(
  parameter int ACC_W = 32,
  parameter int M     = 2,
  parameter int N     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic signed [ACC_W-1:0] C [M][N],
  output logic [ACC_W-1:0]        m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    drop_err,
  input  logic                    err_clr
);

  localparam int TOTAL = M * N;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic LAST_ON_CAPTURE = (TOTAL == 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]       state_r, state_n;
  logic [IDX_W-1:0] idx_r, idx_n, idx_inc_s;
  logic [ACC_W-1:0] buf_r [TOTAL];
  logic [ACC_W-1:0] tdata_r, tdata_n;
  logic             tlast_r, tlast_n;
  logic             drop_err_r;
  logic             handshake_s;
  logic             capture_s;
  logic             drop_s;

  // tvalid and busy both come straight from the state register, never from tready
  assign m_axis_tvalid = (state_r == ST_STREAM);
  assign busy          = (state_r == ST_STREAM);
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tlast  = tlast_r;
  assign drop_err      = drop_err_r;

  assign handshake_s = (state_r == ST_STREAM) && m_axis_tready;
  assign idx_inc_s   = idx_r + IDX_W'(1);

  // Next-state, next-beat and capture/drop decisions
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    tdata_n   = tdata_r;
    tlast_n   = tlast_r;
    capture_s = 1'b0;
    drop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (done) begin
          capture_s = 1'b1;
          state_n   = ST_STREAM;
          idx_n     = {IDX_W{1'b0}};
          tdata_n   = C[0][0];
          tlast_n   = LAST_ON_CAPTURE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (handshake_s && tlast_r) begin
          // A done landing on the final handshake chains straight into the next matrix
          if (done) begin
            capture_s = 1'b1;
            state_n   = ST_STREAM;
            idx_n     = {IDX_W{1'b0}};
            tdata_n   = C[0][0];
            tlast_n   = LAST_ON_CAPTURE;
          end else begin
            state_n = ST_IDLE;
            idx_n   = {IDX_W{1'b0}};
            tdata_n = {ACC_W{1'b0}};
            tlast_n = 1'b0;
          end
        end else begin
          drop_s = done;
          if (handshake_s) begin
            idx_n   = idx_inc_s;
            tdata_n = buf_r[idx_inc_s];
            tlast_n = (idx_inc_s == LAST_IDX);
          end else begin
            idx_n = idx_r;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = {IDX_W{1'b0}};
        tdata_n = {ACC_W{1'b0}};
        tlast_n = 1'b0;
      end
    endcase
  end

  // Control and output beat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      tdata_r <= {ACC_W{1'b0}};
      tlast_r <= 1'b0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      tdata_r <= tdata_n;
      tlast_r <= tlast_n;
    end
  end

  // Matrix buffer, written only on an accepted capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TOTAL; i++) begin
        buf_r[i] <= {ACC_W{1'b0}};
      end
    end else if (capture_s) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          buf_r[r*N + c] <= C[r][c];
        end
      end
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_err_r <= 1'b0;
    end else if (drop_s) begin
      drop_err_r <= 1'b1;
    end else if (err_clr) begin
      drop_err_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench: stimulus pushes expected beats into a queue, a negedge monitor
// pops and compares every handshake and checks stability while stalled.
module tb_matmul_result_streamer;

  localparam int ACC_W = 32;
  localparam int M     = 2;
  localparam int N     = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    done = 1'b0;
  logic                    err_clr = 1'b0;
  logic                    m_axis_tready = 1'b0;
  logic signed [ACC_W-1:0] c_s [M][N];
  logic [ACC_W-1:0]        m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tlast;
  logic                    busy;
  logic                    drop_err;

  logic [ACC_W:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  matmul_result_streamer #(.ACC_W(ACC_W), .M(M), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .done         (done),
    .C            (c_s),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .drop_err     (drop_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input logic [ACC_W:0] act, input logic [ACC_W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got last=%0b data=%0d expected last=%0b data=%0d",
               name, act[ACC_W], $signed(act[ACC_W-1:0]), exp[ACC_W], $signed(exp[ACC_W-1:0]));
    end
  endtask

  // Monitor: compare each handshake against the scoreboard, and held beats against the prior cycle
  initial begin
    logic           prev_stall;
    logic [ACC_W:0] prev_beat;
    logic [ACC_W:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_bit("hold_tvalid", m_axis_tvalid, 1'b1);
          check_beat("hold_beat", {m_axis_tlast, m_axis_tdata}, prev_beat);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data=%0d expected no beat", $signed(m_axis_tdata));
          end else begin
            e = exp_q.pop_front();
            check_beat("beat", {m_axis_tlast, m_axis_tdata}, e);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic signed [ACC_W-1:0] a, input logic signed [ACC_W-1:0] b,
                       input logic signed [ACC_W-1:0] c, input logic signed [ACC_W-1:0] d);
    c_s[0][0] = a;
    c_s[0][1] = b;
    c_s[1][0] = c;
    c_s[1][1] = d;
  endtask

  task automatic push_c();
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        exp_q.push_back({(r == M-1) && (c == N-1), c_s[r][c]});
      end
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic drain(input string name, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [6:0] pat;

    set_c(32'sd0, 32'sd0, 32'sd0, 32'sd0);
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_tvalid", m_axis_tvalid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_tlast", m_axis_tlast, 1'b0);
    check_bit("rst_drop_err", drop_err, 1'b0);
    check_int("rst_tdata", int'(m_axis_tdata), 0);
    rst = 1'b0;
    tick();

    // Full-rate stream
    m_axis_tready = 1'b1;
    set_c(32'sd53, 32'sd62, 32'sd111, 32'sd130);
    push_c();
    pulse_done();
    check_bit("first_beat_tvalid", m_axis_tvalid, 1'b1);
    check_bit("first_beat_busy", busy, 1'b1);
    drain("full_rate", 10, cyc);
    check_int("full_rate_cycles", cyc, 4);
    check_bit("full_rate_busy_after", busy, 1'b0);
    check_bit("full_rate_tvalid_after", m_axis_tvalid, 1'b0);

    // Back-pressure pattern 1,0,0,1,0,1,1
    pat = 7'b1101001;
    m_axis_tready = 1'b0;
    push_c();
    pulse_done();
    for (int i = 0; i < 7; i++) begin
      m_axis_tready = pat[i];
      tick();
    end
    check_int("stall_pending", exp_q.size(), 0);
    check_bit("stall_busy_after", busy, 1'b0);
    m_axis_tready = 1'b1;

    // Dropped done during second beat; upstream C change must not leak in
    push_c();
    pulse_done();
    tick();
    set_c(32'sd9, 32'sd9, 32'sd9, 32'sd9);
    done = 1'b1;
    err_clr = 1'b1;
    tick();
    done = 1'b0;
    err_clr = 1'b0;
    check_bit("drop_set_wins", drop_err, 1'b1);
    drain("drop", 10, cyc);
    check_bit("drop_sticky", drop_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_bit("drop_cleared", drop_err, 1'b0);

    // Back-to-back matrices with done on the tlast handshake
    set_c(32'sd53, 32'sd62, 32'sd111, 32'sd130);
    push_c();
    pulse_done();
    tick();
    tick();
    tick();
    set_c(32'sd1, -32'sd2, 32'sd3, -32'sd4);
    push_c();
    done = 1'b1;
    tick();
    done = 1'b0;
    check_bit("chain_busy", busy, 1'b1);
    check_bit("chain_tvalid", m_axis_tvalid, 1'b1);
    drain("chain", 10, cyc);
    check_int("chain_cycles", cyc, 4);
    check_bit("chain_no_drop", drop_err, 1'b0);

    // Reset mid-stream after the second beat
    set_c(32'sd53, 32'sd62, 32'sd111, 32'sd130);
    push_c();
    pulse_done();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_bit("midrst_tvalid", m_axis_tvalid, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_tlast", m_axis_tlast, 1'b0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check_bit("postrst_idle", m_axis_tvalid, 1'b0);
    set_c(32'sd5, 32'sd6, 32'sd7, 32'sd8);
    push_c();
    pulse_done();
    drain("postrst", 10, cyc);
    check_int("postrst_cycles", cyc, 4);

    // Extreme values pass through bit-exact
    set_c(32'sh7FFFFFFF, 32'sh80000000, 32'sh80000000, 32'sh7FFFFFFF);
    push_c();
    pulse_done();
    drain("extreme", 10, cyc);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_result_streamer.md
MATMUL_RESULT_STREAMER -- requirements
Module: matmul_result_streamer

Interface
REQ-001 Parameter ACC_W, default 32: signed width of each result element and of the stream data.
REQ-002 Parameter M, default 2: number of result rows.
REQ-003 Parameter N, default 2: number of result columns.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 done  input  1  one-cycle pulse from the matmul core: C is valid this cycle.
REQ-007 C  input  signed [ACC_W-1:0] [M][N]  result matrix from the core; sampled only when done=1.
REQ-008 m_axis_tdata  output  ACC_W  current result element.
REQ-009 m_axis_tvalid  output  1  tdata is valid.
REQ-010 m_axis_tready  input  1  downstream accepts the beat.
REQ-011 m_axis_tlast  output  1  marks the final element of a matrix.
REQ-012 busy  output  1  high while a captured matrix is not fully sent.
REQ-013 drop_err  output  1  sticky flag: a done pulse was discarded.
REQ-014 err_clr  input  1  synchronous clear for drop_err.

Function
REQ-015 States: IDLE and STREAM; busy=1 exactly in STREAM.
REQ-016 IDLE with done=1: copy all M*N elements of C into an internal buffer, zero the element index, go to STREAM.
REQ-017 First beat timing: tvalid=1 with tdata=C[0][0] in the cycle after the done pulse.
REQ-018 Beat order: row-major, C[0][0], C[0][1], ..., C[M-1][N-1]; index i maps to row i/N and column i%N.
REQ-019 A beat transfers on a rising edge where tvalid=1 and tready=1; the index then increments.
REQ-020 While tvalid=1 and tready=0: tdata, tlast and the index hold stable.
REQ-021 tvalid never deasserts before its beat has transferred.
REQ-022 tlast=1 only on index M*N-1.
REQ-023 Handshake on the tlast beat with done=0: go to IDLE; tvalid=0 in the next cycle.
REQ-024 Handshake on the tlast beat with done=1 in the same cycle: capture the new C and stay in STREAM.
- The new matrix's C[0][0] is presented in the next cycle; no bubble.
REQ-025 done=1 in STREAM at any other time: ignore the pulse, leave the buffer unchanged, set drop_err.
REQ-026 err_clr=1: drop_err clears next cycle.
- If err_clr=1 and a drop occurs in the same cycle, the set wins.
REQ-027 The buffer changes only on an accepted capture; upstream changes to C after done do not affect streamed data.
REQ-028 Data passes through bit-exact; no arithmetic, truncation or sign change.
REQ-029 Throughput with tready held high: one beat per cycle, so M*N cycles per matrix.
REQ-030 tvalid must not depend combinationally on tready; tready may depend on tvalid.

Reset
REQ-031 While rst=1, asynchronously force:
- state to IDLE;
- tvalid, tlast, busy, drop_err to 0;
- tdata, the index and the buffer to 0.
REQ-032 rst asserted mid-stream abandons the matrix; no partial beats follow after reset is released.
REQ-033 The first done after reset is accepted as in REQ-016.

Verification
REQ-034 C={{53,62},{111,130}}, done pulse, tready=1 -> beats 53, 62, 111, 130 on 4 consecutive cycles starting one cycle after done; tlast only with 130; busy falls after the last beat.
REQ-035 Same C, tready toggled 1,0,0,1,0,1,1 -> same 4 values in order; each value held stable while stalled; no duplicates or drops.
REQ-036 done while streaming the second beat -> stream still 53, 62, 111, 130; drop_err=1 until err_clr pulses, then 0.
REQ-037 Second done coincident with the tlast handshake, C2={{1,-2},{3,-4}} -> 130 followed immediately by 1, -2, 3, -4 with no bubble; drop_err stays 0.
REQ-038 rst pulsed after the second beat -> tvalid, busy, tlast=0 immediately; a new done then streams the fresh C from C[0][0].
REQ-039 C elements 0x7FFFFFFF and 0x80000000 -> streamed unchanged (sign and MSB preserved).
